// File: rtl/blink_pkg.sv
// Shared definitions for the blink pattern controller: default parameters,
// FSM state encoding and the LED pattern table.
package blink_pkg;

  localparam int DEF_CNT_W      = 27;
  localparam int DEF_NUM_SPEEDS = 4;
  localparam int DEF_PAT_LEN    = 5;
  localparam int DEF_LED_W      = 3;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  // Pattern table, entry 0 in the least significant slot:
  // 100, 010, 001, 111, 000, 110, 011, 101
  localparam logic [7:0][DEF_LED_W-1:0] PATTERN = {
    3'b101, 3'b011, 3'b110, 3'b000, 3'b111, 3'b001, 3'b010, 3'b100
  };

  // Table lookup used for the registered LED output.
  function automatic logic [DEF_LED_W-1:0] pattern_at(input logic [2:0] idx);
    return PATTERN[idx];
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running prescaler with synchronous clear and hold. tick fires when
// the low (CNT_W - speed) bits are all ones, so each speed level halves
// the step period.
module blink_prescaler #(
  parameter int CNT_W = 27,
  parameter int SPD_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             clr,
  input  logic [SPD_W-1:0] speed,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  logic [CNT_W-1:0] low_mask;

  // Counter: clear wins over counting; holds while not running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick decode: bits [CNT_W-1-speed:0] all ones while running.
  always_comb begin
    low_mask = {CNT_W{1'b1}} >> speed;
    tick     = run & (&(cnt | ~low_mask));
  end

endmodule

// File: rtl/blink_pattern_ctrl.sv
// LED blink pattern controller: prescaled stepping through a pattern table,
// speed up/down buttons, run/pause toggle.
// Build option: define BLINK_PATTERN_PINGPONG_EN to make the pattern index
// bounce between its ends instead of wrapping to 0.
// Button inputs are single-cycle, already-debounced pulses; there is no
// handshake, each high cycle is one press.
module blink_pattern_ctrl
  import blink_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_SPEEDS = DEF_NUM_SPEEDS,
  parameter int PAT_LEN    = DEF_PAT_LEN,
  parameter int LED_W      = DEF_LED_W,
  localparam int SPD_W     = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_UP,
  input  logic             BTN_DN,
  input  logic             BTN_PAUSE,
  output logic [LED_W-1:0] LED_RGB,
  output logic [SPD_W-1:0] SPEED,
  output logic             PAUSED,
  output state_t           DBG_STATE,
  output logic [2:0]       DBG_IDX,
  output logic [CNT_W-1:0] DBG_CNT
);

  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(NUM_SPEEDS - 1);
  localparam logic [2:0]       IDX_LAST = 3'(PAT_LEN - 1);

  state_t           state_q, state_d;
  logic             run;
  logic             tick;
  logic             up_ok, dn_ok, speed_chg;
  logic [SPD_W-1:0] speed_q;
  logic [2:0]       idx_q;
  logic [LED_W-1:0] led_q;
  logic [CNT_W-1:0] cnt;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: the pause button toggles between RUN and PAUSE.
  always_comb begin
    state_d = state_q;
    if (BTN_PAUSE) state_d = (state_q == RUN) ? PAUSE : RUN;
  end

  // FSM outputs.
  always_comb begin
    run    = (state_q == RUN);
    PAUSED = (state_q == PAUSE);
  end

  // Speed press decode: simultaneous up+down cancels; saturated presses are no-ops.
  always_comb begin
    up_ok     = BTN_UP & ~BTN_DN & (speed_q != SPD_MAX);
    dn_ok     = BTN_DN & ~BTN_UP & (speed_q != '0);
    speed_chg = up_ok | dn_ok;
  end

  // Speed level register; active in both RUN and PAUSE.
  always_ff @(posedge CLK) begin
    if (RST)        speed_q <= '0;
    else if (up_ok) speed_q <= speed_q + SPD_W'(1);
    else if (dn_ok) speed_q <= speed_q - SPD_W'(1);
  end

  blink_prescaler #(
    .CNT_W (CNT_W),
    .SPD_W (SPD_W)
  ) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .run   (run),
    .clr   (speed_chg),
    .speed (speed_q),
    .cnt   (cnt),
    .tick  (tick)
  );

`ifdef BLINK_PATTERN_PINGPONG_EN
  logic dir_up_q;

  // Pattern index bounces between 0 and the last step; each end is shown once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q    <= '0;
      dir_up_q <= 1'b1;
    end else if (tick) begin
      if (dir_up_q) begin
        if (idx_q == IDX_LAST) begin
          dir_up_q <= 1'b0;
          idx_q    <= idx_q - 3'd1;
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end else begin
        if (idx_q == 3'd0) begin
          dir_up_q <= 1'b1;
          idx_q    <= 3'd1;
        end else begin
          idx_q <= idx_q - 3'd1;
        end
      end
    end
  end
`else
  // Pattern index wraps to 0 after the last step.
  always_ff @(posedge CLK) begin
    if (RST)       idx_q <= '0;
    else if (tick) idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
  end
`endif

  // LED output registered from the table, one clock behind the index.
  always_ff @(posedge CLK) begin
    if (RST) led_q <= LED_W'(pattern_at(3'd0));
    else     led_q <= LED_W'(pattern_at(idx_q));
  end

  assign LED_RGB   = led_q;
  assign SPEED     = speed_q;
  assign DBG_STATE = state_q;
  assign DBG_IDX   = idx_q;
  assign DBG_CNT   = cnt;

endmodule

// File: tb/tb_blink_pattern_ctrl.sv
// Directed bench for blink_pattern_ctrl at CNT_W=4, NUM_SPEEDS=4, PAT_LEN=5.
module tb_blink_pattern_ctrl;
  import blink_pkg::*;

  localparam int CNT_W = 4;
  localparam int NSPD  = 4;
  localparam int PLEN  = 5;
  localparam int LW    = 3;

  logic           clk;
  logic           rst;
  logic           btn_up, btn_dn, btn_pause;
  logic [LW-1:0]  led_rgb;
  logic [1:0]     speed;
  logic           paused;
  state_t         dbg_state;
  logic [2:0]     dbg_idx;
  logic [CNT_W-1:0] dbg_cnt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BLINK_PATTERN_PINGPONG_EN
  localparam logic [2:0] IDX_A = 3'd3;  // first tick after speed-up phase
  localparam logic [2:0] IDX_B = 3'd2;
  localparam logic [2:0] IDX_C = 3'd1;
  localparam logic [2:0] IDX_D = 3'd0;  // tick coincident with speed-down
  localparam logic [2:0] IDX_E = 3'd1;
  logic [2:0] tick_tab [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2,
                                3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
`else
  localparam logic [2:0] IDX_A = 3'd0;
  localparam logic [2:0] IDX_B = 3'd1;
  localparam logic [2:0] IDX_C = 3'd2;
  localparam logic [2:0] IDX_D = 3'd3;
  localparam logic [2:0] IDX_E = 3'd4;
  logic [2:0] tick_tab [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1,
                                3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
`endif

  logic [2:0] led_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b111};

  blink_pattern_ctrl #(
    .CNT_W      (CNT_W),
    .NUM_SPEEDS (NSPD),
    .PAT_LEN    (PLEN),
    .LED_W      (LW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .BTN_UP    (btn_up),
    .BTN_DN    (btn_dn),
    .BTN_PAUSE (btn_pause),
    .LED_RGB   (led_rgb),
    .SPEED     (speed),
    .PAUSED    (paused),
    .DBG_STATE (dbg_state),
    .DBG_IDX   (dbg_idx),
    .DBG_CNT   (dbg_cnt)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle button pulse.
  task automatic press(input logic up, input logic dn, input logic pz);
    btn_up    = up;
    btn_dn    = dn;
    btn_pause = pz;
    clk_n(1);
    btn_up    = 1'b0;
    btn_dn    = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_pause = 1'b0;

    // Reset state
    clk_n(2);
    chk("rst_cnt", 32'(dbg_cnt), 0);
    chk("rst_speed", 32'(speed), 0);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_led", 32'(led_rgb), 32'b100);
    chk("rst_idx", 32'(dbg_idx), 0);
    chk("rst_state", 32'(dbg_state), 32'(RUN));
    rst = 1'b0;

    // Speed 0: one step per 16 clocks, LED lags idx by one clock
    for (int t = 0; t < 4; t++) begin
      clk_n(16);
      chk("s0_idx", 32'(dbg_idx), 32'(t + 1));
      chk("s0_led", 32'(led_rgb), 32'(led_tab[t]));
    end
    clk_n(1);
    chk("s0_led4", 32'(led_rgb), 32'b000);
    chk("s0_cnt", 32'(dbg_cnt), 1);

    // Speed up x4: clears on real changes only
    press(1, 0, 0);
    chk("up1_speed", 32'(speed), 1);
    chk("up1_cnt", 32'(dbg_cnt), 0);
    clk_n(2);
    press(1, 0, 0);
    chk("up2_speed", 32'(speed), 2);
    chk("up2_cnt", 32'(dbg_cnt), 0);
    clk_n(2);
    press(1, 0, 0);
    chk("up3_speed", 32'(speed), 3);
    chk("up3_cnt", 32'(dbg_cnt), 0);
    clk_n(2);
    chk("s3_idx_a", 32'(dbg_idx), 32'(IDX_A));
    press(1, 0, 0);
    chk("up4_speed_sat", 32'(speed), 3);
    chk("up4_cnt_kept", 32'(dbg_cnt), 3);

    // Period 2 at speed 3
    clk_n(1);
    chk("s3_idx_b", 32'(dbg_idx), 32'(IDX_B));
    clk_n(1);
    chk("s3_idx_hold", 32'(dbg_idx), 32'(IDX_B));
    clk_n(2);
    chk("s3_idx_c", 32'(dbg_idx), 32'(IDX_C));
    chk("s3_cnt", 32'(dbg_cnt), 7);

    // Speed down coincident with a tick: both take effect
    press(0, 1, 0);
    chk("dn_tick_idx", 32'(dbg_idx), 32'(IDX_D));
    chk("dn_tick_cnt", 32'(dbg_cnt), 0);
    chk("dn_tick_speed", 32'(speed), 2);

    // Up+down together: no change, no clear
    clk_n(1);
    press(1, 1, 0);
    chk("updn_speed", 32'(speed), 2);
    chk("updn_cnt", 32'(dbg_cnt), 2);
    clk_n(2);
    chk("s2_idx_e", 32'(dbg_idx), 32'(IDX_E));

    // Pause at idx 2
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
    clk_n(32);
    chk("p_idx2", 32'(dbg_idx), 2);
    clk_n(1);
    chk("p_led2", 32'(led_rgb), 32'b001);
    press(0, 0, 1);
    chk("p_paused", 32'(paused), 1);
    chk("p_cnt", 32'(dbg_cnt), 2);
    clk_n(100);
    chk("p_hold_cnt", 32'(dbg_cnt), 2);
    chk("p_hold_idx", 32'(dbg_idx), 2);
    chk("p_hold_led", 32'(led_rgb), 32'b001);
    chk("p_hold_paused", 32'(paused), 1);
    chk("p_hold_state", 32'(dbg_state), 32'(PAUSE));
    press(0, 0, 1);
    chk("r_paused", 32'(paused), 0);
    chk("r_cnt_held", 32'(dbg_cnt), 2);
    clk_n(1);
    chk("r_cnt_resume", 32'(dbg_cnt), 3);
    clk_n(13);
    chk("r_idx3", 32'(dbg_idx), 3);
    chk("r_cnt_wrap", 32'(dbg_cnt), 0);

    // Pause at idx 3, speed button still acts
    press(0, 0, 1);
    chk("p2_led", 32'(led_rgb), 32'b111);
    chk("p2_paused", 32'(paused), 1);
    chk("p2_cnt", 32'(dbg_cnt), 1);
    press(1, 0, 0);
    chk("p2_up_speed", 32'(speed), 1);
    chk("p2_up_cnt", 32'(dbg_cnt), 0);

    // Reset in PAUSE overrides simultaneous buttons
    rst = 1'b1; btn_up = 1'b1; btn_pause = 1'b1;
    clk_n(1);
    rst = 1'b0; btn_up = 1'b0; btn_pause = 1'b0;
    chk("rp_idx", 32'(dbg_idx), 0);
    chk("rp_led", 32'(led_rgb), 32'b100);
    chk("rp_speed", 32'(speed), 0);
    chk("rp_paused", 32'(paused), 0);
    chk("rp_cnt", 32'(dbg_cnt), 0);

    // 12 ticks at speed 0: wrap or ping-pong order
    for (int t = 0; t < 12; t++) begin
      clk_n(16);
      chk("seq_idx", 32'(dbg_idx), 32'(tick_tab[t]));
    end

    // Down at speed 0 saturates and does not clear
    press(0, 1, 0);
    chk("dn_sat_speed", 32'(speed), 0);
    chk("dn_sat_cnt", 32'(dbg_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
